// File: rtl/dds_sweep_core.sv
// Sweepable DDS core: phase accumulator with linear/sawtooth/triangle step sweep,
// quarter-wave sine lookup and a fixed three-stage output pipeline.
module dds_sweep_core #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_mode,
  input  logic [ACC_W-1:0]        cfg_start,
  input  logic [ACC_W-1:0]        cfg_stop,
  input  logic [ACC_W-1:0]        cfg_delta,
  input  logic [ACC_W-1:0]        cfg_phase,
  output logic signed [OUT_W-1:0] sin_out,
  output logic                    out_valid,
  output logic                    sweep_done
);

  localparam int QN  = 2 ** (ADDR_W - 2);
  localparam int AMP = 2 ** (OUT_W - 1) - 1;
  localparam logic [ADDR_W-2:0] QN_I = QN[ADDR_W-2:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  function automatic int qsin(input int k);
    real x;
    x = real'(AMP) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** ADDR_W));
    return $rtoi(x + 0.5);
  endfunction

  // Quarter-wave table, first quadrant inclusive of the peak entry.
  logic [OUT_W-2:0] qtab [0:QN];
  for (genvar k = 0; k <= QN; k++) begin : g_tab
    localparam int V = qsin(k);
    assign qtab[k] = V[OUT_W-2:0];
  end

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, step_q, step_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic [ACC_W-1:0]   start_q, start_d, stop_q, stop_d, delta_q, delta_d, phase_q, phase_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d;
  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [OUT_W-2:0]   mag2_q, mag2_d;
  logic               neg2_q, neg2_d;
  logic [OUT_W-1:0]   sin_q, sin_d;
  logic               done_q, done_d;

  logic               accept, sample, hit_up, hit_dn;
  logic [ACC_W:0]     nxt_up, nxt_dn;
  logic [1:0]         quad;
  logic [ADDR_W-3:0]  low;
  logic [ADDR_W-2:0]  idx;

  assign cfg_ready  = ~reset & (state_q != S_LOAD);
  assign sin_out    = sin_q;
  assign out_valid  = v3_q;
  assign sweep_done = done_q;

  always_comb begin
    accept  = cfg_valid & cfg_ready;
    sample  = en & ((state_q == S_RUN) | (state_q == S_DONE));
    nxt_up  = {1'b0, step_q} + {1'b0, delta_q};
    nxt_dn  = {1'b0, step_q} - {1'b0, delta_q};
    hit_up  = nxt_up >= {1'b0, stop_q};
    hit_dn  = nxt_dn[ACC_W] | (nxt_dn[ACC_W-1:0] <= start_q);

    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    start_d = start_q;
    stop_d  = stop_q;
    delta_d = delta_q;
    phase_d = phase_q;
    done_d  = 1'b0;

    addr1_d = ADDR_W'((acc_q + phase_q) >> (ACC_W - ADDR_W));
    v1_d    = sample;

    quad    = addr1_q[ADDR_W-1 -: 2];
    low     = addr1_q[ADDR_W-3:0];
    idx     = quad[0] ? (QN_I - {1'b0, low}) : {1'b0, low};
    mag2_d  = qtab[idx];
    neg2_d  = quad[1];
    v2_d    = v1_q;

    v3_d    = v2_q;
    sin_d   = sin_q;
    if (v2_q) sin_d = neg2_q ? -{1'b0, mag2_q} : {1'b0, mag2_q};

    unique case (state_q)
      S_LOAD: begin
        acc_d   = '0;
        step_d  = start_q;
        dir_d   = 1'b0;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        v3_d    = 1'b0;
        sin_d   = sin_q;
        state_d = S_RUN;
      end
      S_RUN, S_DONE: begin
        if (en) begin
          acc_d = acc_q + step_q;
          // Step sweeps only in RUN; a zero increment means a fixed tone.
          if (state_q == S_RUN && delta_q != '0) begin
            unique case (mode_q)
              2'b01: begin
                if (hit_up) begin
                  step_d  = stop_q;
                  done_d  = 1'b1;
                  state_d = S_DONE;
                end else begin
                  step_d = nxt_up[ACC_W-1:0];
                end
              end
              2'b10: begin
                if (hit_up) begin
                  step_d = start_q;
                  done_d = 1'b1;
                end else begin
                  step_d = nxt_up[ACC_W-1:0];
                end
              end
              2'b11: begin
                if (!dir_q) begin
                  if (hit_up) begin
                    step_d = stop_q;
                    dir_d  = 1'b1;
                  end else begin
                    step_d = nxt_up[ACC_W-1:0];
                  end
                end else if (hit_dn) begin
                  step_d = start_q;
                  dir_d  = 1'b0;
                  done_d = 1'b1;
                end else begin
                  step_d = nxt_dn[ACC_W-1:0];
                end
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase

    // A new configuration wins over any sweep transition in the same cycle.
    if (accept) begin
      mode_d  = (cfg_start > cfg_stop) ? 2'b00 : cfg_mode;
      start_d = cfg_start;
      stop_d  = cfg_stop;
      delta_d = cfg_delta;
      phase_d = cfg_phase;
      state_d = S_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      delta_q <= '0;
      phase_q <= '0;
      addr1_q <= '0;
      v1_q    <= 1'b0;
      mag2_q  <= '0;
      neg2_q  <= 1'b0;
      v2_q    <= 1'b0;
      sin_q   <= '0;
      v3_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      delta_q <= delta_d;
      phase_q <= phase_d;
      addr1_q <= addr1_d;
      v1_q    <= v1_d;
      mag2_q  <= mag2_d;
      neg2_q  <= neg2_d;
      v2_q    <= v2_d;
      sin_q   <= sin_d;
      v3_q    <= v3_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_core.sv
// Scoreboard bench for dds_sweep_core: a cycle model queues expected samples,
// a monitor pops them whenever the DUT presents out_valid.
module tb_dds_sweep_core;

  logic               clk = 1'b0;
  logic               reset, en, cfg_valid, cfg_ready;
  logic [1:0]         cfg_mode;
  logic [31:0]        cfg_start, cfg_stop, cfg_delta, cfg_phase;
  logic signed [15:0] sin_out;
  logic               out_valid, sweep_done;

  always #5 clk = ~clk;

  dds_sweep_core #(.ACC_W(32), .ADDR_W(12), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_delta(cfg_delta), .cfg_phase(cfg_phase),
    .sin_out(sin_out), .out_valid(out_valid), .sweep_done(sweep_done)
  );

  typedef struct { int val; int due; } exp_t;
  exp_t sb[$];
  int   hist[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   first_cyc = 0, acc_cyc = 0, done_seen = 0, last_val = 0;
  bit   exp_done = 0, exp_rdy = 0;

  // reference model state: 0 idle, 1 load, 2 run, 3 done
  int          m_st = 0;
  logic [31:0] m_acc, m_step, m_start, m_stop, m_delta, m_phase;
  logic [1:0]  m_mode;
  bit          m_dir;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_sin(input logic [31:0] p);
    logic [11:0] a;
    logic [9:0]  lo;
    int          idx, v;
    real         x;
    a   = p[31:20];
    lo  = a[9:0];
    idx = a[10] ? 1024 - int'(lo) : int'(lo);
    x   = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 4096.0);
    v   = $rtoi(x + 0.5);
    return a[11] ? -v : v;
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_edge();
    bit          acc_ok, smp;
    logic [32:0] nu, dn;
    exp_done = 0;
    if (reset) begin
      m_st = 0; m_acc = 0; m_step = 0; m_dir = 0; m_mode = 0;
      m_start = 0; m_stop = 0; m_delta = 0; m_phase = 0;
      sb.delete();
      last_val = 0;
      exp_rdy  = 0;
      return;
    end
    acc_ok = cfg_valid && (m_st != 1);
    smp    = en && (m_st >= 2);
    if (smp) sb.push_back('{val: exp_sin(m_acc + m_phase), due: cyc + 3});
    if (m_st == 1) begin
      m_acc = 0; m_step = m_start; m_dir = 0; m_st = 2;
      sb.delete();
    end else if (smp) begin
      m_acc = m_acc + m_step;
      if (m_st == 2 && m_delta != 0) begin
        nu = {1'b0, m_step} + {1'b0, m_delta};
        dn = {1'b0, m_step} - {1'b0, m_delta};
        case (m_mode)
          2'd1: if (nu >= {1'b0, m_stop}) begin m_step = m_stop; exp_done = 1; m_st = 3; end
                else m_step = nu[31:0];
          2'd2: if (nu >= {1'b0, m_stop}) begin m_step = m_start; exp_done = 1; end
                else m_step = nu[31:0];
          2'd3: if (!m_dir) begin
                  if (nu >= {1'b0, m_stop}) begin m_step = m_stop; m_dir = 1; end
                  else m_step = nu[31:0];
                end else if (dn[32] || dn[31:0] <= m_start) begin
                  m_step = m_start; m_dir = 0; exp_done = 1;
                end else m_step = dn[31:0];
          default: ;
        endcase
      end
    end
    if (acc_ok) begin
      m_mode  = (cfg_start > cfg_stop) ? 2'd0 : cfg_mode;
      m_start = cfg_start; m_stop = cfg_stop; m_delta = cfg_delta; m_phase = cfg_phase;
      m_st    = 1;
    end
    exp_rdy = (m_st != 1);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic configure(input logic [1:0] mode, input logic [31:0] st, input logic [31:0] sp,
                           input logic [31:0] dl, input logic [31:0] ph);
    cfg_valid = 1; cfg_mode = mode; cfg_start = st; cfg_stop = sp; cfg_delta = dl; cfg_phase = ph;
    tick();
    cfg_valid = 0;
    hist.delete();
    acc_cyc = cyc;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      check("cfg_ready", int'(cfg_ready), int'(exp_rdy));
      check("sweep_done", int'(sweep_done), int'(exp_done));
      if (sweep_done) done_seen++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_valid_unexpected", int'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("sin_out", int'(sin_out), e.val);
          check("sample_latency", cyc, e.due);
          last_val = e.val;
          hist.push_back(int'(sin_out));
          if (hist.size() == 1) first_cyc = cyc;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("out_valid_missing", int'(out_valid), 1);
          void'(sb.pop_front());
        end
        check("sin_hold", int'(sin_out), last_val);
      end
    end
  end

  initial begin
    int d0, mn, mx;
    reset = 1; en = 0; cfg_valid = 0; cfg_mode = 0;
    cfg_start = 0; cfg_stop = 0; cfg_delta = 0; cfg_phase = 0;
    run(3);
    reset = 0;
    run(3);

    // Fixed tone, one full period plus two samples.
    en = 1;
    configure(2'd0, 32'h0010_0000, 32'h0010_0000, 32'h0, 32'h0);
    run(4110);
    check("tone_first_valid_delay", first_cyc - acc_cyc, 4);
    check("tone_sample_count", int'(hist.size() >= 4098), 1);
    if (hist.size() >= 4098) begin
      check("tone_s0", hist[0], 0);
      check("tone_s1", hist[1], 50);
      check("tone_s1024", hist[1024], 32767);
      check("tone_s2048", hist[2048], 0);
      check("tone_s3072", hist[3072], -32767);
      check("tone_s4096", hist[4096], 0);
      check("tone_s4097", hist[4097], 50);
      mn = 0; mx = 0;
      foreach (hist[i]) begin
        if (hist[i] < mn) mn = hist[i];
        if (hist[i] > mx) mx = hist[i];
      end
      check("tone_min", mn, -32767);
      check("tone_max", mx, 32767);
    end

    // Phase offsets.
    configure(2'd0, 32'h0010_0000, 32'h0010_0000, 32'h0, 32'h4000_0000);
    run(8);
    check("phase90_s0", hist[0], 32767);
    configure(2'd0, 32'h0010_0000, 32'h0010_0000, 32'h0, 32'h8000_0000);
    run(8);
    check("phase180_s0", hist[0], 0);
    check("phase180_s1", hist[1], -50);

    // Single sweep: steps 1,2,3,4 then hold at 4 in DONE.
    d0 = done_seen;
    configure(2'd1, 32'h0010_0000, 32'h0040_0000, 32'h0010_0000, 32'h0);
    run(14);
    check("single_done_count", done_seen - d0, 1);
    check("single_ready", int'(cfg_ready), 1);
    check("single_s3", hist[3], 302);
    check("single_s4", hist[4], 503);

    // Triangle with a 5-cycle enable gap.
    d0 = done_seen;
    configure(2'd3, 32'h0010_0000, 32'h0040_0000, 32'h0010_0000, 32'h0);
    run(1);
    run(7);
    en = 0; run(5);
    en = 1; run(8);
    en = 0; run(4);
    check("tri_done_count", done_seen - d0, 2);
    check("tri_sample_count", hist.size(), 15);

    // Sawtooth: accept arriving on the completion edge.
    en = 1;
    d0 = done_seen;
    configure(2'd2, 32'h0010_0000, 32'h0040_0000, 32'h0010_0000, 32'h0);
    run(3);
    cfg_valid = 1; cfg_mode = 2'd0; cfg_start = 32'h0020_0000; cfg_stop = 32'h0020_0000;
    tick();
    cfg_valid = 0;
    check("collide_ready_low", int'(cfg_ready), 0);
    run(2);
    check("collide_done_count", done_seen - d0, 1);

    // Reset in the middle of a sawtooth sweep.
    d0 = done_seen;
    configure(2'd2, 32'h0010_0000, 32'h0040_0000, 32'h0010_0000, 32'h0);
    run(10);
    check("saw_done_count", done_seen - d0, 3);
    reset = 1;
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sin_out", int'(sin_out), 0);
    check("rst_sweep_done", int'(sweep_done), 0);
    check("rst_cfg_ready", int'(cfg_ready), 0);
    reset = 0;
    tick();
    check("post_rst_ready", int'(cfg_ready), 1);
    check("post_rst_no_valid", int'(out_valid), 0);

    // start > stop forces a fixed tone at the start step.
    d0 = done_seen;
    configure(2'd2, 32'h0030_0000, 32'h0020_0000, 32'h0010_0000, 32'h0);
    run(20);
    check("forced_done_count", done_seen - d0, 0);
    check("forced_s0", hist[0], 0);
    check("forced_s1", hist[1], 151);
    check("forced_s2", hist[2], 302);

    en = 0;
    run(5);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_core.md
DDS_SWEEP_CORE -- requirements
Module: dds_sweep_core

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32, meaning phase accumulator, step and phase-offset width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning the full-wave phase address width taken from the top of the phase sum.
REQ-003 The block SHALL have parameter OUT_W, default 16, meaning signed sample output width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: sample enable; advances accumulator, sweep and pipeline.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: configuration offer.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: configuration accept.
REQ-009 The block SHALL have port cfg_mode, input, 2 bits: 00 fixed, 01 single sweep, 10 sawtooth repeat, 11 triangle.
REQ-010 The block SHALL have ports cfg_start, cfg_stop, cfg_delta and cfg_phase, each input, ACC_W bits: start step, stop step, per-sample step increment, and phase offset.
REQ-011 The block SHALL have port sin_out, output, OUT_W bits: two's-complement sine sample.
REQ-012 The block SHALL have port out_valid, output, 1 bit: sin_out carries a new sample this cycle.
REQ-013 The block SHALL have port sweep_done, output, 1 bit: one-cycle pulse at each sweep completion point.

Function
REQ-014 Handshake SHALL be: configuration accepted on a rising edge with cfg_valid=1 and cfg_ready=1; all cfg_* captured together in that cycle.
REQ-015 cfg_ready SHALL be 1 in IDLE, RUN and DONE, and 0 in LOAD and while reset=1.
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN, DONE, with transitions as follows.
- Accept in any state -> LOAD.
- LOAD -> RUN after exactly one cycle.
- Mode 01 completion: RUN -> DONE.
- DONE SHALL hold until the next accept.
REQ-017 In LOAD the block SHALL perform: acc <= 0; step <= cfg_start; dir <= up; pipeline valid bits cleared.
REQ-018 If cfg_start > cfg_stop (unsigned), the mode SHALL be forced to 00.
REQ-019 In RUN/DONE with en=1 the block SHALL perform: acc <= acc + step, mod 2^ACC_W, wrap-around silent.
REQ-020 With en=0, acc, step and dir SHALL be frozen, and no sample SHALL enter the pipeline.
REQ-021 Step update (en=1, RUN only) SHALL compute next = step + delta in ACC_W+1 bits; a carry out counts as next > stop.
- Mode 00: step unchanged.
- Mode 01: if next >= stop, then step <= stop, sweep_done pulses, state -> DONE; else step <= next.
- Mode 10: if next >= stop, then step <= cfg_start and sweep_done pulses; else step <= next.
- Mode 11 up: if next >= stop, then step <= stop and dir <= down.
- Mode 11 down: if step - delta <= start (borrow counts as below start), then step <= start, dir <= up and sweep_done pulses; else step <= step - delta.
REQ-022 delta = 0 SHALL give a constant step and never assert sweep_done.
REQ-023 In DONE, generation SHALL continue at step = stop.
REQ-024 Phase address SHALL be addr = (acc + phase)[ACC_W-1 : ACC_W-ADDR_W], with the addition mod 2^ACC_W.
REQ-025 Lookup SHALL be a quarter-wave table of 2^(ADDR_W-2)+1 entries, entry k = round((2^(OUT_W-1)-1) * sin(2*pi*k / 2^ADDR_W)).
REQ-026 Quadrant folding SHALL use q = addr[ADDR_W-1:ADDR_W-2] and low = the remaining bits.
- Table index: low for q = 0 or 2; 2^(ADDR_W-2) - low for q = 1 or 3.
- Sign: negated for q = 2 or 3.
REQ-027 Latency SHALL be fixed at 3 cycles from the acc value to sin_out, in three registered stages.
- Stage 1: phase add.
- Stage 2: table read.
- Stage 3: sign/negate.
REQ-028 out_valid SHALL be the 3-stage delayed copy of (en=1 and state in RUN or DONE).
REQ-029 sin_out SHALL hold its last value when out_valid=0.
REQ-030 Output amplitude SHALL be symmetric, +/-(2^(OUT_W-1)-1); the value -2^(OUT_W-1) SHALL never be produced.
REQ-031 An accept arriving while a sweep_done condition occurs SHALL take priority: LOAD is entered, and sweep_done still pulses that cycle.

Reset
REQ-032 While reset=1 the block SHALL drive state IDLE, acc=0, step=0, dir=up, all captured config=0, pipeline cleared, sin_out=0, out_valid=0, sweep_done=0, cfg_ready=0.
REQ-033 Reset SHALL override all inputs, including cfg_valid and en.
REQ-034 Reset asserted mid-sweep SHALL discard in-flight samples; no out_valid is produced from pre-reset state.
REQ-035 After reset the block SHALL remain in IDLE, with cfg_ready=1 and no output, until the first accept.

Verification (ACC_W=32, ADDR_W=12, OUT_W=16)
REQ-036 Fixed tone: mode 00, start=stop=0x00100000, phase=0, en=1 -> sin_out=0 first, 32767 on valid sample 1024, 0 on 2048, -32767 on 3072, period 4096; out_valid rises 4 cycles after accept (1 LOAD + 3 latency).
REQ-037 Phase offset: as REQ-036 with phase=0x40000000 -> first valid sample 32767; phase=0x80000000 -> first valid sample 0, second -50.
REQ-038 Single sweep: mode 01, start=0x00100000, stop=0x00400000, delta=0x00100000 -> step sequence 1,2,3,4 (x2^20); sweep_done pulses once when step reaches 4; state DONE; cfg_ready stays 1.
REQ-039 Triangle: mode 11, same values -> steps 1,2,3,4,3,2,1,2,...; sweep_done on each return to 1; en toggled low for 5 cycles -> sequence resumes unchanged, with no out_valid for those samples.
REQ-040 Reset/handshake: reset during mode-10 sweep -> next cycle all outputs 0 and cfg_ready=0, then 1; new config with start=0x00300000 > stop=0x00200000 -> constant step 0x00300000, no sweep_done.
